pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 4, meaning register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of each performance counter.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles from halt detection to HALTED (E/M/W drain).
REQ-004 The block SHALL have parameter PC_REG, default 15, meaning the register index that is never forwarded.
REQ-005 The block SHALL have these ports, one clock; reset is synchronous and active-high:
  clk  in  1  clock
  reset  in  1  synchronous active-high reset
  start  in  1  run request
  RA1D, RA2D  in  REG_AW  decode-stage source registers
  RA1E, RA2E  in  REG_AW  execute-stage source registers
  WA3E, WA3M, WA3W  in  REG_AW  destination registers in E/M/W
  MemtoRegE  in  1  load in E
  RegWriteM, RegWriteW  in  1  register write pending in M/W
  BranchTakenE  in  1  taken branch resolved in E
  HaltD  in  1  halt instruction in D
  RetireW  in  1  valid instruction leaves W
  ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 W result, 10 M result
  StallF, StallD, FlushD, FlushE  out  1  pipeline register controls
  Running  out  1  FSM in RUN
  Halted  out  1  FSM in HALTED
  StallCnt, FlushCnt, RetireCnt  out  CNT_W  performance counters

Function
REQ-006 ForwardAE SHALL be 10 when RegWriteM and WA3M==RA1E and RA1E!=PC_REG; else 01 when RegWriteW and WA3W==RA1E and RA1E!=PC_REG; else 00 (M priority over W); ForwardBE identically on RA2E; both combinational, independent of FSM state.
REQ-007 Load-use hazard (LU) SHALL be MemtoRegE and (WA3E==RA1D or WA3E==RA2D).
REQ-008 FSM states SHALL be IDLE, RUN, DRAIN, HALTED.
REQ-009 IDLE: StallF=StallD=1, FlushD=FlushE=0; start=1 -> RUN next cycle.
REQ-010 RUN: LU and not BranchTakenE -> StallF=StallD=FlushE=1, FlushD=0.
REQ-011 RUN: BranchTakenE -> FlushD=FlushE=1, StallF=StallD=0, regardless of LU (branch wins).
REQ-012 RUN: HaltD and not BranchTakenE -> DRAIN next cycle, drain counter loaded with DRAIN_CYCLES-1; HaltD with BranchTakenE SHALL be ignored (halt is squashed).
REQ-013 RUN: HaltD and LU together SHALL stall per REQ-010 and not enter DRAIN that cycle.
REQ-014 DRAIN: StallF=StallD=1, FlushE=1 every cycle; counter decrements; at 0 -> HALTED next cycle.
REQ-015 HALTED: StallF=StallD=1, FlushD=FlushE=0; start=1 -> RUN next cycle, counters retained.
REQ-016 start SHALL be ignored in RUN and DRAIN.
REQ-017 StallCnt SHALL increment by 1 each RUN cycle with StallD=1; FlushCnt each RUN cycle with BranchTakenE=1; RetireCnt each cycle RetireW=1 in any state.
REQ-018 Counters SHALL saturate at 2^CNT_W-1, no wrap.
REQ-019 Running=1 only in RUN; Halted=1 only in HALTED; both registered-state decodes, no input path.

Reset
REQ-020 reset sampled high SHALL, at that edge, force IDLE, clear all counters and drain counter, overriding all other inputs including mid-DRAIN.
REQ-021 Outputs the cycle after reset SHALL be: StallF=StallD=1, FlushD=FlushE=0, Running=Halted=0, counters 0; Forward* per REQ-006.

Structure
REQ-022 FSM state enum and forwarding select encodings (FWD_RF=00, FWD_WB=01, FWD_MEM=10) SHALL live in shared package pipeline_pkg.
REQ-023 Forwarding logic SHALL be one sub-module fwd_select, instantiated twice (operand A, B).
REQ-024 Counters SHALL be a single saturating counter sub-module instantiated three times.

Verification
REQ-025 Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; RA1E=15, both matching -> 00.
REQ-026 Load-use: RUN, MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0, StallCnt +1.
REQ-027 Branch vs load-use same cycle: LU and BranchTakenE=1 -> FlushD=FlushE=1, StallF=StallD=0, FlushCnt +1, StallCnt unchanged.
REQ-028 Halt: HaltD=1 one cycle in RUN -> exactly DRAIN_CYCLES=3 cycles DRAIN, then Halted=1; start=1 -> Running=1 next cycle, counters kept.
REQ-029 Reset mid-DRAIN: reset=1 during second DRAIN cycle -> next cycle IDLE, Running=Halted=0, all counters 0.
REQ-030 Saturation: CNT_W=4, RetireW=1 for 20 cycles -> RetireCnt stops at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the hazard controller: run-control FSM states and
// operand forwarding select encodings.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } hazState_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one execute-stage source register.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int PC_REG = 15
) (
  input  logic [REG_AW-1:0] raE,
  input  logic [REG_AW-1:0] wa3M,
  input  logic [REG_AW-1:0] wa3W,
  input  logic              regWriteM,
  input  logic              regWriteW,
  output logic [1:0]        forward
);

  localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

  // The PC is read from its own path, so it never takes a bypassed value.
  always_comb begin
    forward = FWD_RF;
    if (raE != PC_IDX) begin
      if (regWriteM && (wa3M == raE)) begin
        forward = FWD_MEM;
      end else if (regWriteW && (wa3W == raE)) begin
        forward = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] countReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= '0;
    end else if (inc && (countReg != {W{1'b1}})) begin
      countReg <= countReg + W'(1);
    end
  end

  assign count = countReg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// flush, halt drain sequencing and performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3,
  parameter int PC_REG       = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              MemtoRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              BranchTakenE,
  input  logic              HaltD,
  input  logic              RetireW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              Running,
  output logic              Halted,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic [CNT_W-1:0]  RetireCnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  hazState_t          stateReg, stateNext;
  logic [DRAIN_W-1:0] drainReg, drainNext;
  logic               loadUse;

  fwd_select #(.REG_AW(REG_AW), .PC_REG(PC_REG)) uFwdA (
    .raE(RA1E), .wa3M(WA3M), .wa3W(WA3W),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(ForwardAE)
  );

  fwd_select #(.REG_AW(REG_AW), .PC_REG(PC_REG)) uFwdB (
    .raE(RA2E), .wa3M(WA3M), .wa3W(WA3W),
    .regWriteM(RegWriteM), .regWriteW(RegWriteW), .forward(ForwardBE)
  );

  assign loadUse = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      drainReg <= '0;
    end else begin
      stateReg <= stateNext;
      drainReg <= drainNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    drainNext = drainReg;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    case (stateReg)
      IDLE: begin
        StallF = 1'b1;
        StallD = 1'b1;
        if (start) stateNext = RUN;
      end
      RUN: begin
        // A taken branch squashes everything younger, including a halt in D.
        if (BranchTakenE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (loadUse) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (HaltD) begin
          stateNext = DRAIN;
          drainNext = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (drainReg == '0) stateNext = HALTED;
        else                drainNext = drainReg - DRAIN_W'(1);
      end
      HALTED: begin
        StallF = 1'b1;
        StallD = 1'b1;
        if (start) stateNext = RUN;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign Running = (stateReg == RUN);
  assign Halted  = (stateReg == HALTED);

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk(clk), .reset(reset), .inc(Running && StallD), .count(StallCnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk(clk), .reset(reset), .inc(Running && BranchTakenE), .count(FlushCnt)
  );

  sat_counter #(.W(CNT_W)) uRetireCnt (
    .clk(clk), .reset(reset), .inc(RetireW), .count(RetireCnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: forwarding table, directed run-control
// sequences and randomized cycles against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int AW      = 4;
  localparam int CW      = 4;
  localparam int DRAIN_N = 3;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic          MemtoRegE, RegWriteM, RegWriteW, BranchTakenE, HaltD, RetireW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE, Running, Halted;
  logic [CW-1:0] StallCnt, FlushCnt, RetireCnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .DRAIN_CYCLES(DRAIN_N), .PC_REG(15)) dut (
    .clk(clk), .reset(reset), .start(start),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .BranchTakenE(BranchTakenE), .HaltD(HaltD), .RetireW(RetireW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Running(Running), .Halted(Halted),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RetireCnt(RetireCnt)
  );

  int vecCount  = 0;
  int missCount = 0;
  int cycNum    = 0;

  // Model: mode 0 idle, 1 run, 2 drain, 3 halted; mLeft = drain cycles still to go.
  int mMode, mLeft, mStall, mFlush, mRetire;

  typedef struct {
    logic [AW-1:0] ra1E, ra2E, wa3M, wa3W;
    logic          rwM, rwW;
    logic [1:0]    expA, expB;
  } fwdVec_t;

  fwdVec_t fwdTab[8];

  task automatic check(string name, int act, int exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cycNum);
    end
  endtask

  function automatic int fwdRef(logic [AW-1:0] ra);
    if (ra == 4'd15) return 0;
    if (RegWriteM && WA3M == ra) return 2;
    if (RegWriteW && WA3W == ra) return 1;
    return 0;
  endfunction

  function automatic int satInc(int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic clearIns();
    start = 0; RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
    WA3E = 0; WA3M = 0; WA3W = 0; MemtoRegE = 0; RegWriteM = 0;
    RegWriteW = 0; BranchTakenE = 0; HaltD = 0; RetireW = 0;
  endtask

  task automatic modelReset();
    mMode = 0; mLeft = 0; mStall = 0; mFlush = 0; mRetire = 0;
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  task automatic step(string tag);
    bit lu, eSF, eSD, eFD, eFE, incS, incF;
    int nMode, nLeft;
    #2;
    lu = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
    eSF = 0; eSD = 0; eFD = 0; eFE = 0; incS = 0; incF = 0;
    nMode = mMode; nLeft = mLeft;
    case (mMode)
      0: begin eSF = 1; eSD = 1; if (start) nMode = 1; end
      1: begin
        if (BranchTakenE) begin eFD = 1; eFE = 1; incF = 1; end
        else if (lu) begin eSF = 1; eSD = 1; eFE = 1; incS = 1; end
        else if (HaltD) begin nMode = 2; nLeft = DRAIN_N; end
      end
      2: begin
        eSF = 1; eSD = 1; eFE = 1;
        nLeft = mLeft - 1;
        if (nLeft == 0) nMode = 3;
      end
      default: begin eSF = 1; eSD = 1; if (start) nMode = 1; end
    endcase
    check({tag, ".ForwardAE"}, ForwardAE, fwdRef(RA1E));
    check({tag, ".ForwardBE"}, ForwardBE, fwdRef(RA2E));
    check({tag, ".StallF"}, StallF, eSF);
    check({tag, ".StallD"}, StallD, eSD);
    check({tag, ".FlushD"}, FlushD, eFD);
    check({tag, ".FlushE"}, FlushE, eFE);
    check({tag, ".Running"}, Running, (mMode == 1) ? 1 : 0);
    check({tag, ".Halted"}, Halted, (mMode == 3) ? 1 : 0);
    check({tag, ".StallCnt"}, StallCnt, mStall);
    check({tag, ".FlushCnt"}, FlushCnt, mFlush);
    check({tag, ".RetireCnt"}, RetireCnt, mRetire);
    $display("cyc %0d %s mode=%0d st=%0d fl=%0d rt=%0d", cycNum, tag, mMode, mStall, mFlush, mRetire);
    @(posedge clk);
    cycNum++;
    if (reset) begin
      modelReset();
    end else begin
      mMode = nMode; mLeft = nLeft;
      if (incS) mStall = satInc(mStall);
      if (incF) mFlush = satInc(mFlush);
      if (RetireW) mRetire = satInc(mRetire);
    end
    #1;
  endtask

  initial begin
    fwdTab[0] = '{4'd3,  4'd4,  4'd3,  4'd3,  1'b1, 1'b1, 2'b10, 2'b00};
    fwdTab[1] = '{4'd3,  4'd4,  4'd3,  4'd3,  1'b0, 1'b1, 2'b01, 2'b00};
    fwdTab[2] = '{4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 2'b00, 2'b00};
    fwdTab[3] = '{4'd2,  4'd7,  4'd7,  4'd2,  1'b1, 1'b1, 2'b01, 2'b10};
    fwdTab[4] = '{4'd5,  4'd5,  4'd5,  4'd5,  1'b0, 1'b0, 2'b00, 2'b00};
    fwdTab[5] = '{4'd6,  4'd6,  4'd1,  4'd6,  1'b1, 1'b1, 2'b01, 2'b01};
    fwdTab[6] = '{4'd9,  4'd9,  4'd9,  4'd1,  1'b1, 1'b0, 2'b10, 2'b10};
    fwdTab[7] = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 2'b10, 2'b10};

    clearIns();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    modelReset();
    step("after_reset");

    // Forwarding table, state is IDLE and stays there.
    for (int i = 0; i < 8; i++) begin
      RA1E = fwdTab[i].ra1E; RA2E = fwdTab[i].ra2E;
      WA3M = fwdTab[i].wa3M; WA3W = fwdTab[i].wa3W;
      RegWriteM = fwdTab[i].rwM; RegWriteW = fwdTab[i].rwW;
      #2;
      check($sformatf("fwd_tab%0d.A", i), ForwardAE, fwdTab[i].expA);
      check($sformatf("fwd_tab%0d.B", i), ForwardBE, fwdTab[i].expB);
      $display("fwd vector %0d A=%b B=%b", i, ForwardAE, ForwardBE);
      @(posedge clk); cycNum++; #1;
    end
    clearIns();

    start = 1; step("start"); start = 0;
    check("run_entered", Running, 1);

    MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 0;
    step("load_use");
    check("lu_stallcnt", StallCnt, 1);

    BranchTakenE = 1;
    step("branch_vs_lu");
    check("br_flushcnt", FlushCnt, 1);
    check("br_stallcnt", StallCnt, 1);
    clearIns();

    HaltD = 1; step("halt"); HaltD = 0;
    for (int k = 0; k < DRAIN_N; k++) begin
      check($sformatf("drain%0d.FlushE", k), FlushE, 1);
      check($sformatf("drain%0d.Halted", k), Halted, 0);
      step("drain");
    end
    check("halted_after_drain", Halted, 1);
    step("halted");
    start = 1; step("restart"); start = 0;
    check("restart_running", Running, 1);
    check("restart_stallcnt", StallCnt, 1);
    check("restart_flushcnt", FlushCnt, 1);

    HaltD = 1; RetireW = 1; step("halt2"); HaltD = 0;
    step("drain_a");
    reset = 1; step("reset_mid_drain"); reset = 0; RetireW = 0;
    check("rst_running", Running, 0);
    check("rst_halted", Halted, 0);
    check("rst_stallcnt", StallCnt, 0);
    check("rst_flushcnt", FlushCnt, 0);
    check("rst_retirecnt", RetireCnt, 0);

    RetireW = 1;
    for (int k = 0; k < 20; k++) step("retire_sat");
    RetireW = 0;
    check("retire_saturated", RetireCnt, 15);

    for (int n = 0; n < 300; n++) begin
      reset        = ($urandom_range(0, 63) == 0);
      start        = ($urandom_range(0, 3) == 0);
      RA1D         = AW'($urandom_range(0, 3));
      RA2D         = AW'($urandom_range(0, 3));
      RA1E         = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 3));
      RA2E         = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 3));
      WA3E         = AW'($urandom_range(0, 3));
      WA3M         = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 3));
      WA3W         = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 3));
      MemtoRegE    = ($urandom_range(0, 2) == 0);
      RegWriteM    = $urandom_range(0, 1) != 0;
      RegWriteW    = $urandom_range(0, 1) != 0;
      BranchTakenE = ($urandom_range(0, 4) == 0);
      HaltD        = ($urandom_range(0, 7) == 0);
      RetireW      = $urandom_range(0, 1) != 0;
      step("rand");
    end
    clearIns();
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
